// File: rtl/esp_uart_tx_arbiter_pkg.sv
// esp_uart_pkg: arbiter state type, byte width and index-width helper shared by the
// ESP UART TX arbiter files.
package esp_uart_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int ESP_BYTE_W = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/esp_uart_tx_arbiter_if.sv
// esp_uart_tx_arbiter_if: per-requester byte streams in, one shared UART TX byte stream out.
// master = arbiter side, slave = requesters/UART side.
interface esp_uart_tx_arbiter_if import esp_uart_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = ESP_BYTE_W
);

    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_last;
    logic [NUM_REQ-1:0]        in_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_last;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (
        input  in_valid, in_data, in_last, tx_ready,
        output in_ready, tx_data, tx_last, tx_valid
    );

    modport slave (
        output in_valid, in_data, in_last, tx_ready,
        input  in_ready, tx_data, tx_last, tx_valid
    );

endinterface

// File: rtl/esp_uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick -- lowest requesting index at or above ptr,
// wrapping past NUM_REQ-1 back to 0.
module rr_pick import esp_uart_pkg::*; #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   win,
    output logic               any_req
);

    logic [IDX_W-1:0] p;

    // Scan farthest-first so the nearest requester at or after ptr is written last.
    always_comb begin
        win = '0;
        p   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            p = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[p]) win = p;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/esp_uart_tx_arbiter.sv
// esp_uart_tx_arbiter: packet-granular round-robin sharing of the ESP UART TX byte stream.
// Define ESP_ARB_TIMEOUT_EN to abort a grant whose owner stalls mid-packet.
module esp_uart_tx_arbiter import esp_uart_pkg::*; #(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_W         = ESP_BYTE_W,
    parameter  int TIMEOUT_CYCLES = 1024,
    parameter  int CNT_W          = 16,
    localparam int IDX_W          = idx_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    esp_uart_tx_arbiter_if.master bus,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_idx,
    output logic [CNT_W-1:0]     pkt_count,
    output logic                 timeout_pulse
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("esp_uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    arb_state_t        state, state_nx;
    logic [IDX_W-1:0]  ptr, win;
    logic              any_req, slot, acc, done, tout, leave;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_last_q, tx_valid_q;
    logic [CNT_W-1:0]  pkt_q;
    logic [DATA_W-1:0] in_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign in_bytes[g] = bus.in_data[g*DATA_W +: DATA_W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .win     (win),
        .any_req (any_req)
    );

    // Output slot is free when empty or draining this cycle: no bubble within a packet.
    assign slot  = ~tx_valid_q | bus.tx_ready;
    assign acc   = busy & bus.in_valid[grant_idx] & slot;
    assign done  = acc & bus.in_last[grant_idx];
    assign leave = done | tout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ARB_IDLE;
        else          state <= state_nx;
    end

    always_comb
        state_nx = (state == ARB_IDLE) ? (any_req ? ARB_GRANT : ARB_IDLE)
                                       : (leave   ? ARB_IDLE  : ARB_GRANT);

    always_comb begin
        busy         = state == ARB_GRANT;
        bus.in_ready = (busy && slot) ? NUM_REQ'(1) << grant_idx : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_idx <= '0;
            ptr       <= '0;
        end else begin
            if (state == ARB_IDLE && any_req) grant_idx <= win;
            if (busy && leave) ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_q  <= '0;
            tx_last_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            pkt_q      <= '0;
        end else begin
            if (acc) begin
                tx_data_q <= in_bytes[grant_idx];
                tx_last_q <= bus.in_last[grant_idx];
            end
            tx_valid_q <= acc | (tx_valid_q & ~bus.tx_ready);
            if (done) pkt_q <= pkt_q + 1'b1;
        end
    end

`ifdef ESP_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            pulse_q;

    // Only owner silence counts; UART backpressure never ages the grant.
    assign tout = busy & ~bus.in_valid[grant_idx] & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt  <= '0;
            pulse_q <= 1'b0;
        end else begin
            to_cnt  <= (!busy || acc || tout) ? '0 : to_cnt + TO_W'(!bus.in_valid[grant_idx]);
            pulse_q <= tout;
        end
    end

    assign timeout_pulse = pulse_q;
`else
    assign tout          = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_last  = tx_last_q;
    assign bus.tx_valid = tx_valid_q;
    assign pkt_count    = pkt_q;

endmodule
